i2s_tx_sample_feeder: RTL and testbench

Upstream feeder for the I2S transmitter. Accepts interleaved left/right audio words on an AXI4-Stream slave and packs them into a stereo-pair FIFO. On each `next_dac_sample` pulse from the transmitter it pops one pair onto `hphone_l`/`hphone_r`, which it holds stable for the transmitter to load. It counts underruns and framing errors for software visibility.

---
 rtl/i2s_tx_sample_feeder.sv | 139 +++++++++++++
 tb/tb_i2s_tx_sample_feeder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_sample_feeder.sv
// i2s_tx_sample_feeder: packs interleaved L/R AXI4-Stream words into a stereo-pair
// FIFO and presents one pair per next_dac_sample pulse to the I2S transmitter.
// Optional build macro: UNDERRUN_MUTE_EN (zero the outputs on an underrun pop).
module i2s_tx_sample_feeder #(
  parameter int DATA_WIDTH      = 32,
  parameter int AUDIO_WIDTH     = 24,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                       clk_125,
  input  logic                       S_AXIS_ARESETN,
  input  logic                       S_AXIS_TVALID,
  input  logic [DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic                       S_AXIS_TLAST,
  output logic                       S_AXIS_TREADY,
  input  logic                       next_dac_sample,
  output logic [AUDIO_WIDTH-1:0]     hphone_l,
  output logic                       hphone_l_valid,
  output logic [AUDIO_WIDTH-1:0]     hphone_r,
  output logic                       hphone_r_valid,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]                underrun_count,
  output logic [7:0]                 frame_err_count
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int LW    = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {ST_LEFT, ST_RIGHT, ST_RESYNC} asm_state_t;

  asm_state_t                   state;
  logic [AUDIO_WIDTH-1:0]       left_hold;
  logic [2*AUDIO_WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr;
  logic [AUDIO_WIDTH-1:0]       sample;
  logic                         full;
  logic                         empty;
  logic                         beat;
  logic                         wr_en;
  logic                         pop_en;
  logic                         underrun;
  logic                         frame_err;
  logic                         unused_tdata_lsbs;

  // Samples are MSB-justified in the stream word; the low bits carry nothing.
  assign sample            = S_AXIS_TDATA[DATA_WIDTH-1 -: AUDIO_WIDTH];
  assign unused_tdata_lsbs = ^S_AXIS_TDATA[DATA_WIDTH-AUDIO_WIDTH-1:0];

  assign full  = (fifo_level == LW'(DEPTH));
  assign empty = (fifo_level == '0);

  // Entering RIGHT already implies a free slot (only writer), so only LEFT gates on full.
  assign S_AXIS_TREADY = (state == ST_LEFT) ? !full : 1'b1;
  assign beat          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign wr_en         = beat && (state == ST_RIGHT) && S_AXIS_TLAST;
  assign frame_err     = beat && (((state == ST_LEFT)  &&  S_AXIS_TLAST) ||
                                  ((state == ST_RIGHT) && !S_AXIS_TLAST));
  // Emptiness is judged before this cycle's write: a same-cycle write is never bypassed.
  assign pop_en        = next_dac_sample && !empty;
  assign underrun      = next_dac_sample &&  empty;

  // Input assembler: pairs left/right beats and resynchronises on TLAST after a framing slip.
  always_ff @(posedge clk_125 or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state     <= ST_LEFT;
      left_hold <= '0;
    end else if (beat) begin
      case (state)
        ST_LEFT: begin
          if (!S_AXIS_TLAST) begin
            left_hold <= sample;
            state     <= ST_RIGHT;
          end
        end
        ST_RIGHT:  state <= S_AXIS_TLAST ? ST_LEFT : ST_RESYNC;
        ST_RESYNC: if (S_AXIS_TLAST) state <= ST_LEFT;
        default:   state <= ST_LEFT;
      endcase
    end
  end

  // Pair storage; contents need no reset since level/pointers define validity.
  always_ff @(posedge clk_125) begin
    if (wr_en) mem[wr_ptr] <= {left_hold, sample};
  end

  // FIFO pointers and occupancy; pointers wrap naturally modulo depth.
  always_ff @(posedge clk_125 or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_en})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Output pair register: loads the head on a good pop, holds (or mutes) on an underrun.
  always_ff @(posedge clk_125 or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      hphone_l       <= '0;
      hphone_r       <= '0;
      hphone_l_valid <= 1'b0;
      hphone_r_valid <= 1'b0;
    end else begin
      hphone_l_valid <= pop_en;
      hphone_r_valid <= pop_en;
      if (pop_en) begin
        {hphone_l, hphone_r} <= mem[rd_ptr];
      end
`ifdef UNDERRUN_MUTE_EN
      else if (underrun) begin
        hphone_l <= '0;
        hphone_r <= '0;
      end
`endif
    end
  end

  // Software-visible error counters, saturating at all-ones.
  always_ff @(posedge clk_125 or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      underrun_count  <= '0;
      frame_err_count <= '0;
    end else begin
      if (underrun && (underrun_count != 16'hFFFF))
        underrun_count <= underrun_count + 1'b1;
      if (frame_err && (frame_err_count != 8'hFF))
        frame_err_count <= frame_err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sample_feeder.sv
// Bench for i2s_tx_sample_feeder: directed scenarios plus a randomized run
// against a queue-based reference model of the stereo-pair feeder.
// Honors UNDERRUN_MUTE_EN the same way the design does.
module tb_i2s_tx_sample_feeder;

  logic        clk_125 = 1'b0;
  logic        rst_n;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        tready;
  logic        nds;
  logic [23:0] hl, hr;
  logic        hlv, hrv;
  logic [4:0]  level;
  logic [15:0] ucnt;
  logic [7:0]  fcnt;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pairs, assembler phase, held outputs, counters.
  logic [47:0] mq[$];
  int          m_phase;   // 0 expect left, 1 expect right, 2 resync
  logic [23:0] m_left, m_l, m_r;
  logic        m_vld;
  int          m_under, m_ferr;
  logic        rdy_seen, rdy_exp;

  i2s_tx_sample_feeder dut (
    .clk_125(clk_125), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TDATA(tdata), .S_AXIS_TLAST(tlast),
    .S_AXIS_TREADY(tready), .next_dac_sample(nds),
    .hphone_l(hl), .hphone_l_valid(hlv), .hphone_r(hr), .hphone_r_valid(hrv),
    .fifo_level(level), .underrun_count(ucnt), .frame_err_count(fcnt)
  );

  always #4 clk_125 = ~clk_125;

  function automatic logic model_ready();
    return (m_phase != 0) || (mq.size() < 16);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_left = '0; m_l = '0; m_r = '0; m_vld = 1'b0;
    m_under = 0; m_ferr = 0;
  endtask

  // One clock: drive at negedge, sample ready, update model at posedge, settle #1.
  task automatic step(input logic tv, input logic [31:0] td, input logic tl,
                      input logic pop, output logic acc);
    logic [47:0] pr;
    @(negedge clk_125);
    tvalid = tv; tdata = td; tlast = tl; nds = pop;
    #1;
    rdy_seen = tready;
    rdy_exp  = model_ready();
    acc      = tv && rdy_exp;
    @(posedge clk_125);
    m_vld = 1'b0;
    if (pop) begin
      if (mq.size() > 0) begin
        pr = mq.pop_front();
        m_l = pr[47:24]; m_r = pr[23:0]; m_vld = 1'b1;
      end else begin
        if (m_under < 16'hFFFF) m_under++;
`ifdef UNDERRUN_MUTE_EN
        m_l = '0; m_r = '0;
`endif
      end
    end
    if (acc) begin
      case (m_phase)
        0: if (tl) begin if (m_ferr < 255) m_ferr++; end
           else begin m_left = td[31:8]; m_phase = 1; end
        1: if (tl) begin mq.push_back({m_left, td[31:8]}); m_phase = 0; end
           else begin if (m_ferr < 255) m_ferr++; m_phase = 2; end
        default: if (tl) m_phase = 0;
      endcase
    end
    #1;
  endtask

  // Offer a beat until accepted, bounded.
  task automatic send_beat(input logic [31:0] td, input logic tl, input logic pop);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, td, tl, pop, acc);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_beat_timeout data=%h tready_seen=%b required accept", td, rdy_seen);
    end
  endtask

  task automatic idle(input logic pop);
    logic acc;
    step(1'b0, 32'h0, 1'b0, pop, acc);
  endtask

  task automatic do_reset();
    @(negedge clk_125);
    rst_n = 1'b0; tvalid = 1'b0; nds = 1'b0;
    model_reset();
    @(negedge clk_125);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_125);
    rst_n = 1'b0; tvalid = 1'b1; tdata = 32'hDEAD_BE00; tlast = 1'b0; nds = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({hl, hr, hlv, hrv, level, ucnt, fcnt, tready} !== {48'h0, 2'b00, 5'd0, 16'd0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state l=%h r=%h v=%b%b lvl=%0d u=%0d f=%0d rdy=%b required all 0, rdy=1",
               hl, hr, hlv, hrv, level, ucnt, fcnt, tready);
    end
    @(posedge clk_125); #1;
    checks++;
    if ({hlv, level, ucnt, fcnt} !== 30'd0) begin
      errors++;
      $display("FAIL reset_hold_ignores_inputs v=%b lvl=%0d u=%0d f=%0d required 0", hlv, level, ucnt, fcnt);
    end
    @(negedge clk_125);
    rst_n = 1'b1; tvalid = 1'b0; nds = 1'b0;
  endtask

  task automatic test_passthrough();
    do_reset();
    send_beat(32'hAABBCC00, 1'b0, 1'b0);
    send_beat(32'h11223300, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd1) begin errors++; $display("FAIL pass_level_after_write got %0d required 1", level); end
    idle(1'b1);
    checks++;
    if ({hl, hr, hlv, hrv, level} !== {24'hAABBCC, 24'h112233, 2'b11, 5'd0}) begin
      errors++;
      $display("FAIL pass_pop l=%h r=%h v=%b%b lvl=%0d required aabbcc 112233 11 0", hl, hr, hlv, hrv, level);
    end
    idle(1'b0);
    checks++;
    if ({hlv, hrv, hl} !== {2'b00, 24'hAABBCC}) begin
      errors++;
      $display("FAIL pass_valid_one_cycle v=%b%b l=%h required 00 aabbcc", hlv, hrv, hl);
    end
  endtask

  task automatic test_fill();
    logic acc;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send_beat({8'(i), 16'hA000, 8'h00}, 1'b0, 1'b0);
      send_beat({8'(i), 16'hB000, 8'h00}, 1'b1, 1'b0);
    end
    step(1'b1, 32'h77777700, 1'b0, 1'b0, acc);
    checks++;
    if ({level, rdy_seen} !== {5'd16, 1'b0}) begin
      errors++;
      $display("FAIL fill_full lvl=%0d rdy=%b required 16 0", level, rdy_seen);
    end
    idle(1'b1);
    checks++;
    if ({tready, level, hl} !== {1'b1, 5'd15, 24'h00A000}) begin
      errors++;
      $display("FAIL fill_pop_reopens rdy=%b lvl=%0d l=%h required 1 15 00a000", tready, level, hl);
    end
    send_beat(32'h77777700, 1'b0, 1'b0);
    send_beat(32'h88888800, 1'b1, 1'b0);
    checks++;
    if (level !== 5'd16) begin errors++; $display("FAIL fill_17th_accepted lvl=%0d required 16", level); end
  endtask

  task automatic test_underrun();
    logic [23:0] el, er;
    do_reset();
    send_beat(32'h00012300, 1'b0, 1'b0);
    send_beat(32'h00045600, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checks++;
      if ({hlv, hrv} !== 2'b00) begin errors++; $display("FAIL underrun_no_valid v=%b%b required 00", hlv, hrv); end
    end
`ifdef UNDERRUN_MUTE_EN
    el = 24'h0; er = 24'h0;
`else
    el = 24'h000123; er = 24'h000456;
`endif
    checks++;
    if ({ucnt, hl, hr} !== {16'd3, el, er}) begin
      errors++;
      $display("FAIL underrun_count_outputs u=%0d l=%h r=%h required 3 %h %h", ucnt, hl, hr, el, er);
    end
  endtask

  task automatic test_framing();
    do_reset();
    send_beat(32'h01010100, 1'b1, 1'b0);
    send_beat(32'h02020200, 1'b0, 1'b0);
    send_beat(32'h03030300, 1'b0, 1'b0);
    send_beat(32'h04040400, 1'b1, 1'b0);
    send_beat(32'h0A0B0C00, 1'b0, 1'b0);
    send_beat(32'h0D0E0F00, 1'b1, 1'b0);
    checks++;
    if ({fcnt, level} !== {8'd2, 5'd1}) begin
      errors++;
      $display("FAIL framing ferr=%0d lvl=%0d required 2 1", fcnt, level);
    end
    idle(1'b1);
    checks++;
    if ({hl, hr} !== {24'h0A0B0C, 24'h0D0E0F}) begin
      errors++;
      $display("FAIL framing_pair l=%h r=%h required 0a0b0c 0d0e0f", hl, hr);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_beat(32'h11111100, 1'b0, 1'b0);
    send_beat(32'h22222200, 1'b1, 1'b0);
    send_beat(32'h33333300, 1'b0, 1'b0);
    send_beat(32'h44444400, 1'b1, 1'b1);
    checks++;
    if ({level, hl, hr, hlv} !== {5'd1, 24'h111111, 24'h222222, 1'b1}) begin
      errors++;
      $display("FAIL simul_nonempty lvl=%0d l=%h r=%h v=%b required 1 111111 222222 1", level, hl, hr, hlv);
    end
    idle(1'b1);
    send_beat(32'h55555500, 1'b0, 1'b0);
    send_beat(32'h66666600, 1'b1, 1'b1);
    checks++;
    if ({level, ucnt, hlv, hl} !== {5'd1, 16'd1, 1'b0, m_l}) begin
      errors++;
      $display("FAIL simul_empty lvl=%0d u=%0d v=%b l=%h required 1 1 0 %h", level, ucnt, hlv, hl, m_l);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    send_beat(32'h99999900, 1'b0, 1'b0);
    do_reset();
    send_beat(32'hABABAB00, 1'b1, 1'b0);
    checks++;
    if ({fcnt, level} !== {8'd1, 5'd0}) begin
      errors++;
      $display("FAIL reset_midframe ferr=%0d lvl=%0d required 1 0", fcnt, level);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) send_beat(32'h0, 1'b1, 1'b0);
    checks++;
    if (fcnt !== 8'hFF) begin errors++; $display("FAIL ferr_saturate got %0d required 255", fcnt); end
  endtask

  task automatic test_random();
    logic acc, tog, tl, tv, pop;
    do_reset();
    tog = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tv  = ($urandom % 4) != 0;
      tl  = (($urandom % 10) == 0) ? ~tog : tog;
      pop = (i < 300) ? (($urandom % 6) == 0) : (($urandom % 2) == 0);
      step(tv, $urandom, tl, pop, acc);
      if (acc) tog = ~tl;
      checks++;
      if ({rdy_seen, hl, hr, hlv, hrv, level, ucnt, fcnt} !==
          {rdy_exp, m_l, m_r, m_vld, m_vld, 5'(mq.size()), 16'(m_under), 8'(m_ferr)}) begin
        errors++;
        $display("FAIL random_cycle_%0d rdy=%b l=%h r=%h v=%b%b lvl=%0d u=%0d f=%0d required rdy=%b l=%h r=%h v=%b lvl=%0d u=%0d f=%0d",
                 i, rdy_seen, hl, hr, hlv, hrv, level, ucnt, fcnt,
                 rdy_exp, m_l, m_r, m_vld, mq.size(), m_under, m_ferr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; nds = 1'b0;
    model_reset();
    test_reset();
    test_passthrough();
    test_fill();
    test_underrun();
    test_framing();
    test_simultaneous();
    test_reset_midframe();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
